// File: rtl/tmp_pkg.sv
// Shared types, defaults and helpers for the temperature-sensor decimator.
package tmp_pkg;

  // Default build: 1024 decisions per window, 16 settling decisions dropped.
  localparam int N_LOG2_DEF  = 10;
  localparam int DISCARD_DEF = 16;

  // Widest code any legal build can produce (N_LOG2 up to 14, plus one bit).
  localparam int MAX_CODE_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  // max(a - b, 0); callers zero-extend into and truncate out of MAX_CODE_W.
  function automatic logic [MAX_CODE_W-1:0] sat_sub(
    input logic [MAX_CODE_W-1:0] a,
    input logic [MAX_CODE_W-1:0] b
  );
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/tmp_decim_cnt.sv
// Strobe-qualified counter: advances on en_i, wraps to zero after LAST,
// and flags the terminal value so the owner can act on that same strobe.
module tmp_decim_cnt #(
  parameter int W    = 4,
  parameter int LAST = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt_q;

  // Count register with synchronous reset and clear; wraps on the terminal strobe.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST_V) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == LAST_V);

endmodule

// File: rtl/tmp_decim.sv
// Sinc1 decimator for the temperature-sensor comparator bitstream: drops a
// settling prefix, counts ones over 2^N_LOG2 decisions, subtracts a latched
// offset with saturation and presents the code on a valid/ready handshake.
module tmp_decim
  import tmp_pkg::*;
#(
  parameter int N_LOG2  = N_LOG2_DEF,
  parameter int DISCARD = DISCARD_DEF,
  parameter int CODE_W  = N_LOG2 + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              cmp,
  input  logic              cmp_strobe,
  input  logic [CODE_W-1:0] offset,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);

  // Settling counter only needs to reach DISCARD-1; keep at least one bit.
  localparam int DISC_W    = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam int DISC_LAST = (DISCARD > 0) ? DISCARD - 1 : 0;
  localparam int DEC_LAST  = (1 << N_LOG2) - 1;

  // Conversions skip SETTLE entirely when there is no prefix to drop.
  localparam state_e FIRST_STATE = (DISCARD > 0) ? ST_SETTLE : ST_ACCUM;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] ones_q, ones_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] offset_q, offset_d;
  logic              overrun_q, overrun_d;

  logic              disc_tc, dec_tc;
  logic              disc_en, dec_en;
  logic              cnt_clr;
  logic [CODE_W-1:0] ones_sum;

  assign disc_en  = cmp_strobe && (state_q == ST_SETTLE);
  assign dec_en   = cmp_strobe && (state_q == ST_ACCUM);
  // Holding counters clear in IDLE leaves every fresh conversion at zero.
  assign cnt_clr  = (state_q == ST_IDLE);
  // Cannot overflow: at most 2^N_LOG2-1 ones before the final add.
  assign ones_sum = ones_q + {{(CODE_W-1){1'b0}}, cmp};

  tmp_decim_cnt #(
    .W    (DISC_W),
    .LAST (DISC_LAST)
  ) u_disc_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (disc_en),
    .tc_o    (disc_tc)
  );

  tmp_decim_cnt #(
    .W    (N_LOG2),
    .LAST (DEC_LAST)
  ) u_dec_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (dec_en),
    .tc_o    (dec_tc)
  );

  // Next-state, accumulator, result and overrun logic.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    code_d    = code_q;
    offset_d  = offset_q;
    overrun_d = overrun_q;

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          offset_d = offset;
          state_d  = FIRST_STATE;
        end
      end
      ST_SETTLE: begin
        if (cmp_strobe && disc_tc) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cmp_strobe) begin
          if (dec_tc) begin
            code_d  = CODE_W'(sat_sub(MAX_CODE_W'(ones_sum), MAX_CODE_W'(offset_q)));
            ones_d  = '0;
            state_d = ST_OUT;
          end else begin
            ones_d = ones_sum;
          end
        end
      end
      ST_OUT: begin
        // A decision arriving while the result is unread is lost; flag it.
        // Placed after the clear so a same-cycle set wins.
        if (cmp_strobe) begin
          overrun_d = 1'b1;
        end
        if (ready) begin
          state_d = continuous ? FIRST_STATE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ones_q    <= '0;
      code_q    <= '0;
      offset_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      code_q    <= code_d;
      offset_q  <= offset_d;
      overrun_q <= overrun_d;
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == ST_OUT);
  assign busy    = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tmp_decim.sv
// Directed bench for tmp_decim with N_LOG2=4 and DISCARD=2. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_tmp_decim;

  localparam int N_LOG2  = 4;
  localparam int DISCARD = 2;
  localparam int CODE_W  = N_LOG2 + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              continuous;
  logic              cmp;
  logic              cmp_strobe;
  logic [CODE_W-1:0] offset;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              overrun;
  logic              clr_overrun;

  int n_checks = 0;
  int n_errors = 0;

  tmp_decim #(
    .N_LOG2  (N_LOG2),
    .DISCARD (DISCARD),
    .CODE_W  (CODE_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .continuous  (continuous),
    .cmp         (cmp),
    .cmp_strobe  (cmp_strobe),
    .offset      (offset),
    .code        (code),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // All helpers are entered and left on a falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobe(input logic v);
    cmp_strobe = 1'b1;
    cmp        = v;
    @(negedge clk);
    cmp_strobe = 1'b0;
    cmp        = 1'b0;
  endtask

  task automatic strobes(input int n, input logic v);
    for (int i = 0; i < n; i++) strobe(v);
  endtask

  task automatic pulse_start(input int off);
    offset = CODE_W'(off);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    continuous  = 1'b0;
    cmp         = 1'b0;
    cmp_strobe  = 1'b0;
    offset      = '0;
    ready       = 1'b1;
    clr_overrun = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    tick();

    // T1: 18 ones, first 2 dropped -> 16; valid one cycle after last strobe
    pulse_start(0);
    check("t1_busy_after_start", int'(busy), 1);
    strobes(17, 1'b1);
    check("t1_valid_before_last", int'(valid), 0);
    check("t1_busy_before_last", int'(busy), 1);
    strobe(1'b1);
    check("t1_valid", int'(valid), 1);
    check("t1_code", int'(code), 16);
    check("t1_busy_out", int'(busy), 0);
    tick();
    check("t1_valid_drop", int'(valid), 0);
    check("t1_busy_idle", int'(busy), 0);

    // T2: alternating 1,0 over 16 counted -> 8 ones, offset 3 -> 5
    pulse_start(3);
    strobes(2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1);
      strobe(1'b0);
    end
    check("t2_valid", int'(valid), 1);
    check("t2_code", int'(code), 5);
    tick();

    // T3: all zeros, offset 4 -> saturates to 0
    pulse_start(4);
    strobes(2, 1'b1);
    strobes(16, 1'b0);
    check("t3_valid", int'(valid), 1);
    check("t3_code", int'(code), 0);
    tick();

    // T4: consumer stalls; strobes in OUT set overrun and are dropped
    ready = 1'b0;
    pulse_start(0);
    strobes(18, 1'b1);
    check("t4_valid", int'(valid), 1);
    check("t4_code", int'(code), 16);
    check("t4_overrun_pre", int'(overrun), 0);
    strobes(3, 1'b0);
    check("t4_code_held", int'(code), 16);
    check("t4_overrun", int'(overrun), 1);
    check("t4_valid_held", int'(valid), 1);
    clr_overrun = 1'b1;
    strobe(1'b1);
    clr_overrun = 1'b0;
    check("t4_set_beats_clr", int'(overrun), 1);
    ready = 1'b1;
    tick();
    check("t4_valid_after_ready", int'(valid), 0);
    check("t4_overrun_sticky", int'(overrun), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t4_overrun_clr", int'(overrun), 0);

    // T5: continuous mode, back-to-back ones then zeros -> 16 then 0
    continuous = 1'b1;
    pulse_start(0);
    strobes(18, 1'b1);
    check("t5_valid_a", int'(valid), 1);
    check("t5_code_a", int'(code), 16);
    tick();
    check("t5_restart_busy", int'(busy), 1);
    check("t5_restart_valid", int'(valid), 0);
    continuous = 1'b0;
    strobes(17, 1'b0);
    check("t5_valid_early", int'(valid), 0);
    strobe(1'b0);
    check("t5_valid_b", int'(valid), 1);
    check("t5_code_b", int'(code), 0);
    check("t5_overrun", int'(overrun), 0);
    tick();
    check("t5_idle_valid", int'(valid), 0);
    check("t5_idle_busy", int'(busy), 0);

    // T6: reset mid-conversion, then a fresh run with a start while busy
    pulse_start(0);
    strobes(9, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_valid", int'(valid), 0);
    check("t6_rst_code", int'(code), 0);
    pulse_start(0);
    strobes(5, 1'b1);
    start  = 1'b1;
    offset = CODE_W'(7);
    strobe(1'b1);
    start  = 1'b0;
    strobes(11, 1'b1);
    check("t6_valid_early", int'(valid), 0);
    strobe(1'b1);
    check("t6_valid", int'(valid), 1);
    check("t6_code", int'(code), 16);
    tick();
    check("t6_valid_drop", int'(valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
